// File: rtl/prime_pkg.sv
// Shared definitions for the prime generator: FSM state encoding, default width, first prime.
// Latency: none (package only).
// Backpressure: none (package only).
package prime_pkg;

    localparam int WIDTH_DEFAULT = 16;
    localparam int FIRST_PRIME   = 2;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        TEST = 3'd1,
        WAIT = 3'd2,
        EMIT = 3'd3,
        NEXT = 3'd4,
        FIN  = 3'd5
    } state_t;

endpackage

// File: rtl/prime_generator_rem_unit.sv
// Iterative restoring remainder: rem = dividend % divisor, one quotient bit per cycle.
// Latency: rdy pulses WIDTH cycles after the cycle go is sampled; rem is valid with rdy.
// Backpressure: none; go restarts the unit at any time, and the result holds until the next go.
// Ports: clk, rst_n (async active-low), go, dividend, divisor (never 0) -> rem, rdy.
module rem_unit
    import prime_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             go,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem,
    output logic             rdy
);

    localparam int CW = $clog2(WIDTH) + 1;

    logic [WIDTH-1:0] dvd_q;
    logic [WIDTH-1:0] dsr_q;
    logic [WIDTH-1:0] rem_q;
    logic [CW-1:0]    cnt_q;
    logic             run_q;
    logic             rdy_q;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] rem_step;

    // Bring the next dividend bit into the partial remainder and subtract the
    // divisor if it fits. The partial remainder is always < divisor, so the
    // shifted value needs one extra bit and the difference's top bit is the borrow.
    always_comb begin
        shifted  = {rem_q, dvd_q[WIDTH-1]};
        diff     = shifted - {1'b0, dsr_q};
        rem_step = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dvd_q <= '0;
            dsr_q <= '0;
            rem_q <= '0;
            cnt_q <= '0;
            run_q <= 1'b0;
            rdy_q <= 1'b0;
        end else if (go) begin
            dvd_q <= dividend;
            dsr_q <= divisor;
            rem_q <= '0;
            cnt_q <= '0;
            run_q <= 1'b1;
            rdy_q <= 1'b0;
        end else if (run_q) begin
            rem_q <= rem_step;
            dvd_q <= {dvd_q[WIDTH-2:0], 1'b0};
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == CW'(WIDTH - 1)) begin
                run_q <= 1'b0;
                rdy_q <= 1'b1;
            end else begin
                rdy_q <= 1'b0;
            end
        end else begin
            rdy_q <= 1'b0;
        end
    end

    assign rem = rem_q;
    assign rdy = rdy_q;

endmodule

// File: rtl/prime_generator.sv
// Prime source: after start, streams every prime 2..limit in ascending order via trial division.
// Latency: first prime valid 3 cycles after start; each trial divide costs WIDTH cycles.
// Backpressure: prime_out/prime_valid hold until prime_ready; the search stalls meanwhile.
// Ports: clk, rst_n, start, limit -> prime_out, prime_valid (with prime_ready in), busy, done.
module prime_generator
    import prime_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] prime_out,
    output logic             prime_valid,
    input  logic             prime_ready,
    output logic             busy,
    output logic             done
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] cand_q, cand_d;
    logic [WIDTH-1:0] div_q, div_d;
    logic [WIDTH-1:0] limit_q, limit_d;
    logic [WIDTH-1:0] prime_out_q, prime_out_d;
    logic             prime_valid_q, prime_valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [2*WIDTH-1:0] div_ext;
    logic [2*WIDTH-1:0] div_sq;
    logic               sq_gt;
    logic               rem_go;
    logic [WIDTH-1:0]   rem_val;
    logic               rem_rdy;

    // Full-width square so the stop test never overflows for large divisors.
    assign div_ext = {{WIDTH{1'b0}}, div_q};
    assign div_sq  = div_ext * div_ext;
    assign sq_gt   = div_sq > {{WIDTH{1'b0}}, cand_q};
    assign rem_go  = (state_q == TEST) && !sq_gt;

    rem_unit #(.WIDTH(WIDTH)) u_rem (
        .clk      (clk),
        .rst_n    (rst_n),
        .go       (rem_go),
        .dividend (cand_q),
        .divisor  (div_q),
        .rem      (rem_val),
        .rdy      (rem_rdy)
    );

    always_comb begin
        state_d       = state_q;
        cand_d        = cand_q;
        div_d         = div_q;
        limit_d       = limit_q;
        prime_out_d   = prime_out_q;
        prime_valid_d = prime_valid_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    limit_d = limit;
                    cand_d  = WIDTH'(FIRST_PRIME);
                    div_d   = WIDTH'(FIRST_PRIME);
                    busy_d  = 1'b1;
                    state_d = (limit < WIDTH'(FIRST_PRIME)) ? FIN : TEST;
                end
            end
            TEST: begin
                state_d = sq_gt ? EMIT : WAIT;
            end
            WAIT: begin
                if (rem_rdy) begin
                    if (rem_val == '0) begin
                        state_d = NEXT;
                    end else begin
                        div_d   = div_q + 1'b1;
                        state_d = TEST;
                    end
                end
            end
            EMIT: begin
                // First EMIT cycle registers the output; afterwards wait for the handshake.
                if (!prime_valid_q) begin
                    prime_valid_d = 1'b1;
                    prime_out_d   = cand_q;
                end else if (prime_ready) begin
                    prime_valid_d = 1'b0;
                    state_d       = NEXT;
                end
            end
            NEXT: begin
                // Equality stop keeps cand from wrapping when limit is all-ones.
                if (cand_q == limit_q) begin
                    state_d = FIN;
                end else begin
                    cand_d  = cand_q + 1'b1;
                    div_d   = WIDTH'(FIRST_PRIME);
                    state_d = TEST;
                end
            end
            FIN: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cand_q        <= '0;
            div_q         <= '0;
            limit_q       <= '0;
            prime_out_q   <= '0;
            prime_valid_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cand_q        <= cand_d;
            div_q         <= div_d;
            limit_q       <= limit_d;
            prime_out_q   <= prime_out_d;
            prime_valid_q <= prime_valid_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    assign prime_out   = prime_out_q;
    assign prime_valid = prime_valid_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_prime_generator.sv
module tb_prime_generator;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] limit;
    logic [15:0] prime_out;
    logic        prime_valid;
    logic        prime_ready;
    logic        busy;
    logic        done;

    int          n_pass   = 0;
    int          n_checks = 0;
    logic [15:0] got[$];
    logic        done_seen;
    logic        busy_at_done;

    // Hand-listed primes up to 97.
    logic [15:0] primes [25] = '{16'd2, 16'd3, 16'd5, 16'd7, 16'd11, 16'd13, 16'd17,
                                 16'd19, 16'd23, 16'd29, 16'd31, 16'd37, 16'd41, 16'd43,
                                 16'd47, 16'd53, 16'd59, 16'd61, 16'd67, 16'd71, 16'd73,
                                 16'd79, 16'd83, 16'd89, 16'd97};

    prime_generator #(.WIDTH(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .limit       (limit),
        .prime_out   (prime_out),
        .prime_valid (prime_valid),
        .prime_ready (prime_ready),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic do_start(input logic [15:0] lim);
        @(negedge clk);
        start = 1'b1;
        limit = lim;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Samples at the current negedge first, then advances; stops on the done pulse.
    task automatic collect(input int budget);
        done_seen = 1'b0;
        for (int c = 0; c < budget && !done_seen; c++) begin
            if (prime_valid && prime_ready) got.push_back(prime_out);
            if (done) begin
                done_seen    = 1'b1;
                busy_at_done = busy;
            end else begin
                @(negedge clk);
            end
        end
    endtask

    task automatic check_stream(input string tag, input int lim);
        int n;
        n = 0;
        for (int i = 0; i < 25; i++) if (int'(primes[i]) <= lim) n++;
        check({tag, "_count"}, got.size(), n);
        for (int i = 0; i < n && i < got.size(); i++)
            check($sformatf("%s_p%0d", tag, i), got[i], primes[i]);
        check({tag, "_done_seen"}, done_seen, 1);
        check({tag, "_busy_at_done"}, busy_at_done, 0);
        @(negedge clk);
        check({tag, "_done_one_cycle"}, done, 0);
    endtask

    initial begin
        logic has89, has97, has91, has93, has95;
        rst_n       = 1'b0;
        start       = 1'b0;
        limit       = 16'd0;
        prime_ready = 1'b1;
        busy_at_done = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_prime_out", prime_out, 0);
        check("rst_prime_valid", prime_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        rst_n = 1'b1;

        // 1: limit=30 with ready held high
        got.delete();
        do_start(16'd30);
        check("t1_busy", busy, 1);
        collect(5000);
        check_stream("t1", 30);

        // 2: empty runs
        got.delete();
        do_start(16'd1);
        collect(3);
        check("t2a_count", got.size(), 0);
        check("t2a_done_seen", done_seen, 1);
        check("t2a_busy_at_done", busy_at_done, 0);
        got.delete();
        do_start(16'd0);
        collect(3);
        check("t2b_count", got.size(), 0);
        check("t2b_done_seen", done_seen, 1);

        // 3: limit=97
        got.delete();
        do_start(16'd97);
        collect(20000);
        has89 = 0; has97 = 0; has91 = 0; has93 = 0; has95 = 0;
        foreach (got[i]) begin
            if (got[i] == 16'd89) has89 = 1;
            if (got[i] == 16'd97) has97 = 1;
            if (got[i] == 16'd91) has91 = 1;
            if (got[i] == 16'd93) has93 = 1;
            if (got[i] == 16'd95) has95 = 1;
        end
        check("t3_has_89", has89, 1);
        check("t3_has_97", has97, 1);
        check("t3_no_91", has91, 0);
        check("t3_no_93", has93, 0);
        check("t3_no_95", has95, 0);
        check_stream("t3", 97);

        // 4: backpressure on the first prime
        prime_ready = 1'b0;
        got.delete();
        do_start(16'd10);
        @(negedge clk);
        check("t4_valid_cycle2", prime_valid, 0);
        @(negedge clk);
        check("t4_valid_cycle3", prime_valid, 1);
        check("t4_out_cycle3", prime_out, 2);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check($sformatf("t4_hold_valid%0d", i), prime_valid, 1);
            check($sformatf("t4_hold_out%0d", i), prime_out, 2);
        end
        check("t4_busy_stalled", busy, 1);
        prime_ready = 1'b1;
        collect(3000);
        check_stream("t4", 10);

        // 5: start during a run is ignored
        got.delete();
        do_start(16'd30);
        @(negedge clk);
        start = 1'b1;
        limit = 16'd5;
        @(negedge clk);
        start = 1'b0;
        collect(5000);
        check_stream("t5", 30);

        // 6: reset while a divide is in progress, then a fresh short run
        got.delete();
        do_start(16'd50);
        repeat (14) @(negedge clk);
        check("t6_busy_before_rst", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_prime_out", prime_out, 0);
        check("t6_rst_prime_valid", prime_valid, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_done", done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        got.delete();
        do_start(16'd3);
        collect(2000);
        check_stream("t6", 3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
